// File: rtl/alt_vipvfr130_common_stream_packetizer.sv
// alt_vipvfr130_common_stream_packetizer
// Turns the unpacker's pixel beats into Avalon-ST Video: an optional control
// packet, then one SOP/EOP-framed data packet per frame. Pixels are counted
// against the dimensions latched at frame start. At frame end the unpacker is
// told to discard the padding left in its last memory word.
// Optional feature: define VFR_CTRL_PKT_EN to emit a 4-beat control packet
// before every data packet (SYMBOLS must then be 3).
module alt_vipvfr130_common_stream_packetizer #(
  parameter int BPS     = 8,
  parameter int SYMBOLS = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [15:0]              frame_width,
  input  logic [15:0]              frame_height,
  input  logic [3:0]               frame_interlace,
  output logic                     busy,
  output logic                     frame_done,
  input  logic [BPS*SYMBOLS-1:0]   pix_data,
  input  logic                     pix_write,
  output logic                     pix_stall,
  output logic                     unpack_clear,
  output logic [BPS*SYMBOLS-1:0]   dout_data,
  output logic                     dout_valid,
  output logic                     dout_sop,
  output logic                     dout_eop,
  input  logic                     dout_ready
);

  localparam int DATA_WIDTH = BPS * SYMBOLS;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CTRL_HDR  = 3'd1;
  localparam logic [2:0] ST_CTRL_BODY = 3'd2;
  localparam logic [2:0] ST_DATA_HDR  = 3'd3;
  localparam logic [2:0] ST_DATA      = 3'd4;
  localparam logic [2:0] ST_FLUSH     = 3'd5;

  logic [2:0]            state_r;
  logic [15:0]           width_r;
  logic [15:0]           height_r;
  logic [15:0]           x_r;
  logic [15:0]           y_r;
  logic                  busy_r;
  logic                  frame_done_r;
  logic                  unpack_clear_r;
  logic [DATA_WIDTH-1:0] dout_data_r;
  logic                  dout_valid_r;
  logic                  dout_sop_r;
  logic                  dout_eop_r;

  logic                  load_ok_s;
  logic                  pix_accept_s;
  logic                  x_last_s;
  logic                  frame_last_s;

`ifdef VFR_CTRL_PKT_EN
  logic [3:0]            interlace_r;
  logic [1:0]            beat_r;

  // Pack three nibbles into the low bits of symbols 0..2, everything else zero.
  function automatic logic [DATA_WIDTH-1:0] ctrl_beat(input logic [3:0] n0,
                                                      input logic [3:0] n1,
                                                      input logic [3:0] n2);
    logic [DATA_WIDTH-1:0] b;
    b = {DATA_WIDTH{1'b0}};
    b[3:0]         = n0;
    b[BPS +: 4]    = n1;
    b[2*BPS +: 4]  = n2;
    return b;
  endfunction
`else
  logic                  unused_interlace_s;
  assign unused_interlace_s = ^frame_interlace;
`endif

  // The single output stage may take a new beat when empty or draining.
  always_comb begin
    load_ok_s    = ~dout_valid_r | dout_ready;
    pix_accept_s = (state_r == ST_DATA) & pix_write & load_ok_s;
    x_last_s     = (x_r == width_r - 16'd1);
    frame_last_s = x_last_s & (y_r == height_r - 16'd1);
  end

  // Frame sequencing, pixel counting and the output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      width_r        <= 16'd0;
      height_r       <= 16'd0;
      x_r            <= 16'd0;
      y_r            <= 16'd0;
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
      unpack_clear_r <= 1'b0;
      dout_data_r    <= {DATA_WIDTH{1'b0}};
      dout_valid_r   <= 1'b0;
      dout_sop_r     <= 1'b0;
      dout_eop_r     <= 1'b0;
`ifdef VFR_CTRL_PKT_EN
      interlace_r    <= 4'd0;
      beat_r         <= 2'd0;
`endif
    end else begin
      frame_done_r   <= 1'b0;
      unpack_clear_r <= 1'b0;
      // A transferred beat empties the stage unless a state below refills it.
      if (load_ok_s) begin
        dout_valid_r <= 1'b0;
        dout_sop_r   <= 1'b0;
        dout_eop_r   <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            if ((frame_width != 16'd0) && (frame_height != 16'd0)) begin
              width_r  <= frame_width;
              height_r <= frame_height;
              x_r      <= 16'd0;
              y_r      <= 16'd0;
              busy_r   <= 1'b1;
`ifdef VFR_CTRL_PKT_EN
              interlace_r <= frame_interlace;
              state_r     <= ST_CTRL_HDR;
`else
              state_r     <= ST_DATA_HDR;
`endif
            end else begin
              // Empty frame: nothing to stream, just acknowledge.
              frame_done_r <= 1'b1;
            end
          end
        end
`ifdef VFR_CTRL_PKT_EN
        ST_CTRL_HDR: begin
          if (load_ok_s) begin
            dout_data_r  <= ctrl_beat(4'hF, 4'h0, 4'h0);
            dout_valid_r <= 1'b1;
            dout_sop_r   <= 1'b1;
            dout_eop_r   <= 1'b0;
            beat_r       <= 2'd0;
            state_r      <= ST_CTRL_BODY;
          end
        end
        ST_CTRL_BODY: begin
          if (load_ok_s) begin
            dout_valid_r <= 1'b1;
            dout_sop_r   <= 1'b0;
            beat_r       <= beat_r + 2'd1;
            case (beat_r)
              2'd0: begin
                dout_data_r <= ctrl_beat(width_r[15:12], width_r[11:8], width_r[7:4]);
                dout_eop_r  <= 1'b0;
              end
              2'd1: begin
                dout_data_r <= ctrl_beat(width_r[3:0], height_r[15:12], height_r[11:8]);
                dout_eop_r  <= 1'b0;
              end
              default: begin
                dout_data_r <= ctrl_beat(height_r[7:4], height_r[3:0], interlace_r);
                dout_eop_r  <= 1'b1;
                state_r     <= ST_DATA_HDR;
              end
            endcase
          end
        end
`endif
        ST_DATA_HDR: begin
          if (load_ok_s) begin
            dout_data_r  <= {DATA_WIDTH{1'b0}};
            dout_valid_r <= 1'b1;
            dout_sop_r   <= 1'b1;
            dout_eop_r   <= 1'b0;
            state_r      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (pix_accept_s) begin
            dout_data_r  <= pix_data;
            dout_valid_r <= 1'b1;
            dout_sop_r   <= 1'b0;
            dout_eop_r   <= frame_last_s;
            if (x_last_s) begin
              x_r <= 16'd0;
              y_r <= y_r + 16'd1;
            end else begin
              x_r <= x_r + 16'd1;
            end
            if (frame_last_s) begin
              state_r <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // The EOP beat leaves the stage this cycle (or already has).
          if (load_ok_s) begin
            unpack_clear_r <= 1'b1;
            frame_done_r   <= 1'b1;
            busy_r         <= 1'b0;
            state_r        <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pix_stall    = ~((state_r == ST_DATA) & load_ok_s);
  assign busy         = busy_r;
  assign frame_done   = frame_done_r;
  assign unpack_clear = unpack_clear_r;
  assign dout_data    = dout_data_r;
  assign dout_valid   = dout_valid_r;
  assign dout_sop     = dout_sop_r;
  assign dout_eop     = dout_eop_r;

endmodule

// File: doc/alt_vipvfr130_common_stream_packetizer.md
Name: alt_vipvfr130_common_stream_packetizer

Overview:
- Sits directly downstream of the pixel unpacker in the frame reader output path.
- Consumes one pixel per accepted beat from the unpacker and emits Avalon-ST Video: an optional control packet, then one data packet per frame, with SOP/EOP framing.
- Counts pixels per frame against latched dimensions.
- At frame end it pulses clear to the unpacker, discarding the padding left in the final memory word.

Parameters:
BPS, 8, bits per colour symbol
SYMBOLS, 3, symbols per beat (parallel); DATA_WIDTH = BPS*SYMBOLS; fixed at 3 when control packets are compiled in

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
frame_start  in  1  one-cycle request to begin a frame; ignored while busy
frame_width  in  16  pixels per line, sampled on accepted frame_start
frame_height  in  16  lines per frame, sampled on accepted frame_start
frame_interlace  in  4  interlace nibble for the control packet, sampled with dimensions
busy  out  1  high from accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse at frame completion
pix_data  in  DATA_WIDTH  pixel from unpacker
pix_write  in  1  pixel valid from unpacker
pix_stall  out  1  backpressure to unpacker; pixel accepted when pix_write & ~pix_stall
unpack_clear  out  1  one-cycle discard pulse to unpacker
dout_data  out  DATA_WIDTH  stream data
dout_valid  out  1  stream valid
dout_sop  out  1  start of packet
dout_eop  out  1  end of packet
dout_ready  in  1  stream ready; beat transfers when dout_valid & dout_ready (ready latency 0)

Behaviour:
- Reset state: all outputs 0 except pix_stall=1. State IDLE, counters 0.
- Reset mid-frame abandons the frame: no EOP, no frame_done.
- Output register: a single stage. It loads only when empty or transferring (~dout_valid | dout_ready). dout_* hold stable while dout_valid & ~dout_ready.
- pix_stall = ~(state==DATA & (~dout_valid | dout_ready)).
- IDLE: frame_start with width≠0 and height≠0 latches the dimensions, sets busy and moves to CTRL_HDR (macro on) or DATA_HDR.
  - frame_start with width==0 or height==0: no stream output, no busy; frame_done pulses the next cycle.
- CTRL_HDR: load beat with data = 0x...F in symbol0 [3:0], other bits 0, sop=1. Go to CTRL_BODY.
- CTRL_BODY: three beats, each symbol carrying one nibble in [3:0], upper symbol bits 0. Symbol0 is the first nibble of each beat.
  - Beat0: W[15:12], W[11:8], W[7:4].
  - Beat1: W[3:0], H[15:12], H[11:8].
  - Beat2: H[7:4], H[3:0], interlace; eop=1.
  - Then go to DATA_HDR.
- DATA_HDR: load beat with data=0, sop=1. Go to DATA.
- DATA: each accepted pixel loads dout_data=pix_data.
  - x counts 0..W-1 and wraps to 0 while y increments.
  - The pixel with x==W-1 and y==H-1 loads with eop=1. Go to FLUSH.
- FLUSH: wait until the EOP beat has transferred (dout_valid==0 or transferring this cycle). Then assert unpack_clear and frame_done for one cycle, drop busy and go to IDLE.
- Latency: a pixel accepted in cycle N is presented in cycle N+1.
- Throughput is one beat per cycle with dout_ready held high.
- frame_start while busy is ignored, including during FLUSH. Dimension inputs may change freely once latched.
- Counters are 16-bit with no overflow beyond W-1/H-1.
- pix_write while stalled is neither consumed nor counted.

Optional Feature:
- Macro VFR_CTRL_PKT_EN.
- Defined: CTRL_HDR/CTRL_BODY states are present and a 4-beat control packet precedes every data packet.
- Undefined: states omitted; IDLE goes directly to DATA_HDR; frame_interlace is unused; SYMBOLS may be any value ≥1.

Test Plan:
- Macro on, W=4, H=2, interlace=0x3, pixels 0x000001..0x000008, ready=1.
  - Required beats: 0x00000F(sop), 0x000000_nibbles{0,0,0}, {4,0,0}, {0,2,3}(eop), 0x000000(sop), then 8 pixels with eop on 0x000008.
  - unpack_clear and frame_done pulse exactly once, one cycle after the last transfer.
- Same frame with dout_ready toggling 1,0,0,1 repeatedly.
  - dout_data stable while stalled; pix_stall high whenever dout_valid & ~dout_ready.
  - No pixel lost or duplicated; order preserved.
- W=0, H=5, frame_start -> no dout_valid, busy stays 0, frame_done pulses next cycle, no unpack_clear.
- frame_start with W=2, H=2, a second frame_start with W=9 mid-frame -> the second is ignored; exactly 4 data beats; eop on the 4th.
- Reset asserted after 3 of 8 pixels -> next cycle all outputs 0, pix_stall=1. A new W=1, H=1 frame then runs cleanly: header(sop), one pixel(sop=0, eop=1).
- Macro off, W=3, H=1 -> first beat is the data header (sop), then 3 pixels, eop on the 3rd; no 0xF beat ever appears.
